// File: rtl/vx_rop_csr_slave.sv
// vx_rop_csr_slave: ROP-window CSR responder with per-warp register banks
// and a round-robin snapshot publisher toward the ROP pipeline.
// Optional feature: ROP_CSR_WRITE_BYPASS_EN forwards same-cycle write data
// to a matching read (COMMIT status still reports the pre-write state).

`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 44
`endif
`ifndef VX_CSR_ADDR_BITS
`define VX_CSR_ADDR_BITS 12
`endif
`ifndef VX_CSR_ROP_BEGIN
`define VX_CSR_ROP_BEGIN 12'h7C0
`endif

module vx_rop_csr_slave #(
   parameter int NUM_WARPS = `NUM_WARPS,
   parameter int NUM_LANES = 1,
   parameter int PID_WIDTH = 1,
   parameter int NUM_CSRS  = 8,
   parameter logic [`VX_CSR_ADDR_BITS-1:0] CSR_BASE = `VX_CSR_ROP_BEGIN
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             read_enable,
   input  logic [`UUID_WIDTH-1:0]           read_uuid,
   input  logic [PID_WIDTH-1:0]             read_pid,
   input  logic [`NW_WIDTH-1:0]             read_wid,
   input  logic [NUM_LANES-1:0]             read_tmask,
   input  logic [`VX_CSR_ADDR_BITS-1:0]     read_addr,
   output logic [NUM_LANES*32-1:0]          read_data,
   input  logic                             write_enable,
   input  logic [`UUID_WIDTH-1:0]           write_uuid,
   input  logic [PID_WIDTH-1:0]             write_pid,
   input  logic [`NW_WIDTH-1:0]             write_wid,
   input  logic [NUM_LANES-1:0]             write_tmask,
   input  logic [`VX_CSR_ADDR_BITS-1:0]     write_addr,
   input  logic [NUM_LANES*32-1:0]          write_data,
   output logic                             cfg_valid,
   output logic [`NW_WIDTH-1:0]             cfg_wid,
   output logic [(NUM_CSRS-1)*32-1:0]       cfg_data,
   input  logic                             cfg_ready
);

   localparam int NW_W  = `NW_WIDTH;
   localparam int AW    = `VX_CSR_ADDR_BITS;
   localparam int NREGS = NUM_CSRS - 1;

   typedef enum logic {IDLE, HOLD} state_e;

   state_e                 state_q, state_d;
   logic [31:0]            bank_q [NUM_WARPS][NREGS];
   logic [31:0]            bank_d [NUM_WARPS][NREGS];
   logic [NUM_WARPS-1:0]   pending_q, pending_d;
   logic [NW_W-1:0]        last_grant_q, last_grant_d;
   logic [NW_W-1:0]        cfg_wid_q, cfg_wid_d;
   logic [NREGS*32-1:0]    cfg_data_q, cfg_data_d;

   logic [AW-1:0]          rd_off, wr_off;
   logic                   rd_in_range, rd_commit;
   logic                   wr_in_range, wr_valid, wr_commit, wr_reg;
   logic                   wr_lane_found;
   logic [31:0]            wr_lane_data;
   logic [31:0]            rd_word;
   logic                   rd_pending, staged_this_warp;
   logic                   stage_free, grant_found;
   logic [NW_W-1:0]        grant_wid;
   logic                   unused_ok;

   // Debug tags, pids and read lane masks carry no meaning for this block.
   assign unused_ok = ^{read_enable, read_uuid, read_pid, read_tmask, write_uuid, write_pid};

   // Address decode: offset into the ROP window and whether it lands in a bank.
   assign rd_off      = read_addr - CSR_BASE;
   assign wr_off      = write_addr - CSR_BASE;
   assign rd_in_range = (read_addr >= CSR_BASE) && (rd_off < AW'(NUM_CSRS));
   assign wr_in_range = (write_addr >= CSR_BASE) && (wr_off < AW'(NUM_CSRS));
   assign rd_commit   = rd_in_range && (rd_off == AW'(NUM_CSRS - 1));
   assign wr_valid    = write_enable && wr_in_range && wr_lane_found;
   assign wr_commit   = wr_valid && (wr_off == AW'(NUM_CSRS - 1));
   assign wr_reg      = wr_valid && !wr_commit;

   // Write data comes from the lowest-numbered active lane; no active lane drops the write.
   always_comb begin
      wr_lane_found = 1'b0;
      wr_lane_data  = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         if (!wr_lane_found && write_tmask[l]) begin
            wr_lane_found = 1'b1;
            wr_lane_data  = write_data[l*32 +: 32];
         end
      end
   end

   // Read path: bank contents, or COMMIT status {staged, pending}, replicated per lane.
   always_comb begin
      rd_word          = '0;
      rd_pending       = 1'b0;
      staged_this_warp = (state_q == HOLD) && (cfg_wid_q == read_wid);
      for (int w = 0; w < NUM_WARPS; w++) begin
         if (w == int'(read_wid)) rd_pending = pending_q[w];
      end
      if (rd_commit) begin
         rd_word = {30'b0, staged_this_warp, rd_pending};
      end else if (rd_in_range) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            for (int r = 0; r < NREGS; r++) begin
               if (w == int'(read_wid) && r == int'(rd_off)) rd_word = bank_q[w][r];
            end
         end
      end
`ifdef ROP_CSR_WRITE_BYPASS_EN
      if (wr_reg && rd_in_range && !rd_commit && (write_wid == read_wid) && (wr_off == rd_off))
         rd_word = wr_lane_data;
`endif
   end

   assign read_data = {NUM_LANES{rd_word}};

   // Register bank update from a non-COMMIT write.
   always_comb begin
      bank_d = bank_q;
      for (int w = 0; w < NUM_WARPS; w++) begin
         for (int r = 0; r < NREGS; r++) begin
            if (wr_reg && w == int'(write_wid) && r == int'(wr_off)) bank_d[w][r] = wr_lane_data;
         end
      end
   end

   // Publish FSM: load the next round-robin pending warp whenever staging frees up.
   always_comb begin
      int cand;
      state_d      = state_q;
      pending_d    = pending_q;
      last_grant_d = last_grant_q;
      cfg_wid_d    = cfg_wid_q;
      cfg_data_d   = cfg_data_q;
      grant_found  = 1'b0;
      grant_wid    = '0;
      cand         = 0;
      stage_free   = (state_q == IDLE) || cfg_ready;

      for (int k = 1; k <= NUM_WARPS; k++) begin
         cand = (int'(last_grant_q) + k) % NUM_WARPS;
         for (int w = 0; w < NUM_WARPS; w++) begin
            if (!grant_found && w == cand && pending_q[w]) begin
               grant_found = 1'b1;
               grant_wid   = NW_W'(w);
            end
         end
      end

      if (stage_free) begin
         if (grant_found) begin
            state_d      = HOLD;
            cfg_wid_d    = grant_wid;
            last_grant_d = grant_wid;
            for (int w = 0; w < NUM_WARPS; w++) begin
               if (w == int'(grant_wid)) begin
                  pending_d[w] = 1'b0;
                  for (int r = 0; r < NREGS; r++) cfg_data_d[r*32 +: 32] = bank_q[w][r];
               end
            end
         end else begin
            state_d = IDLE;
         end
      end

      // A COMMIT landing in the same cycle its warp is granted must survive.
      for (int w = 0; w < NUM_WARPS; w++) begin
         if (wr_commit && w == int'(write_wid)) pending_d[w] = 1'b1;
      end
   end

   // State registers; reset clears banks, pending commits and any held snapshot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         bank_q       <= '{default: '0};
         pending_q    <= '0;
         last_grant_q <= NW_W'(NUM_WARPS - 1);
         cfg_wid_q    <= '0;
         cfg_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         bank_q       <= bank_d;
         pending_q    <= pending_d;
         last_grant_q <= last_grant_d;
         cfg_wid_q    <= cfg_wid_d;
         cfg_data_q   <= cfg_data_d;
      end
   end

   assign cfg_valid = (state_q == HOLD);
   assign cfg_wid   = cfg_wid_q;
   assign cfg_data  = cfg_data_q;

endmodule

// File: tb/tb_vx_rop_csr_slave.sv
// Testbench for vx_rop_csr_slave: directed vectors, a behavioural model of
// banks/pending/round-robin publishing, and per-cycle output comparison.

`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 44
`endif
`ifndef VX_CSR_ADDR_BITS
`define VX_CSR_ADDR_BITS 12
`endif
`ifndef VX_CSR_ROP_BEGIN
`define VX_CSR_ROP_BEGIN 12'h7C0
`endif

module tb_vx_rop_csr_slave;

   localparam int NW = `NUM_WARPS;
   localparam int NL = 4;
   localparam int NC = 8;
   localparam int NR = NC - 1;
   localparam logic [11:0] BASE = `VX_CSR_ROP_BEGIN;

   logic                          clk;
   logic                          reset;
   logic                          read_enable;
   logic [`UUID_WIDTH-1:0]        read_uuid;
   logic [0:0]                    read_pid;
   logic [`NW_WIDTH-1:0]          read_wid;
   logic [NL-1:0]                 read_tmask;
   logic [11:0]                   read_addr;
   logic [NL*32-1:0]              read_data;
   logic                          write_enable;
   logic [`UUID_WIDTH-1:0]        write_uuid;
   logic [0:0]                    write_pid;
   logic [`NW_WIDTH-1:0]          write_wid;
   logic [NL-1:0]                 write_tmask;
   logic [11:0]                   write_addr;
   logic [NL*32-1:0]              write_data;
   logic                          cfg_valid;
   logic [`NW_WIDTH-1:0]          cfg_wid;
   logic [NR*32-1:0]              cfg_data;
   logic                          cfg_ready;

   int n_compared = 0;
   int n_failed   = 0;

   vx_rop_csr_slave #(.NUM_WARPS(NW), .NUM_LANES(NL), .PID_WIDTH(1), .NUM_CSRS(NC), .CSR_BASE(BASE)) dut (
      .clk(clk), .reset(reset),
      .read_enable(read_enable), .read_uuid(read_uuid), .read_pid(read_pid), .read_wid(read_wid),
      .read_tmask(read_tmask), .read_addr(read_addr), .read_data(read_data),
      .write_enable(write_enable), .write_uuid(write_uuid), .write_pid(write_pid), .write_wid(write_wid),
      .write_tmask(write_tmask), .write_addr(write_addr), .write_data(write_data),
      .cfg_valid(cfg_valid), .cfg_wid(cfg_wid), .cfg_data(cfg_data), .cfg_ready(cfg_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model state
   logic [31:0]   m_bank [NW][NR];
   logic [NW-1:0] m_pend;
   int            m_lg;
   logic          m_sv;
   int            m_swid;
   logic [31:0]   m_sdata [NR];

   function automatic logic [31:0] lane_pick(input logic [NL-1:0] mask, input logic [NL*32-1:0] data);
      logic [31:0] v;
      v = '0;
      for (int l = NL - 1; l >= 0; l--) if (mask[l]) v = data[l*32 +: 32];
      return v;
   endfunction

   function automatic logic [31:0] model_read_word();
      int off;
      logic [31:0] v;
      off = int'(read_addr) - int'(BASE);
      if (off < 0 || off >= NC) return 32'h0;
      if (off == NC - 1) return {30'b0, (m_sv && m_swid == int'(read_wid)), m_pend[read_wid]};
      v = m_bank[read_wid][3'(off)];
`ifdef ROP_CSR_WRITE_BYPASS_EN
      if (write_enable && write_tmask != '0 && write_wid == read_wid && write_addr == read_addr) v = lane_pick(write_tmask, write_data);
`endif
      return v;
   endfunction

   // Model: at each clock, staging is taken first (from the old bank), then the request lands.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int w = 0; w < NW; w++) for (int r = 0; r < NR; r++) m_bank[w][r] = 32'h0;
         for (int r = 0; r < NR; r++) m_sdata[r] = 32'h0;
         m_pend = '0;
         m_lg   = NW - 1;
         m_sv   = 1'b0;
         m_swid = 0;
      end else begin
         int off;
         logic got;
         int g;
         got = 1'b0;
         g   = 0;
         if (!m_sv || cfg_ready) begin
            for (int k = 1; k <= NW; k++) begin
               if (!got && m_pend[(m_lg + k) % NW]) begin
                  got = 1'b1;
                  g   = (m_lg + k) % NW;
               end
            end
            if (got) begin
               m_sv   = 1'b1;
               m_swid = g;
               for (int r = 0; r < NR; r++) m_sdata[r] = m_bank[g][r];
               m_pend[g] = 1'b0;
               m_lg   = g;
            end else begin
               m_sv = 1'b0;
            end
         end
         off = int'(write_addr) - int'(BASE);
         if (write_enable && write_tmask != '0 && off >= 0 && off < NC) begin
            if (off == NC - 1) m_pend[write_wid] = 1'b1;
            else m_bank[write_wid][3'(off)] = lane_pick(write_tmask, write_data);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Compare process: every cycle, mid-period, DUT outputs against the model.
   always @(negedge clk) begin
      logic [NR*32-1:0] exp_data;
      checkOutput("cfg_valid", 256'(cfg_valid), 256'(m_sv));
      if (m_sv) begin
         for (int r = 0; r < NR; r++) exp_data[r*32 +: 32] = m_sdata[r];
         checkOutput("cfg_wid", 256'(cfg_wid), 256'(m_swid));
         checkOutput("cfg_data", 256'(cfg_data), 256'(exp_data));
      end
      if (read_enable) checkOutput("read_data", 256'(read_data), 256'({NL{model_read_word()}}));
   end

   task automatic applyStimulus(input logic we, input logic [1:0] wwid, input logic [11:0] waddr,
                                input logic [NL-1:0] wmask, input logic [NL*32-1:0] wdata,
                                input logic re, input logic [1:0] rwid, input logic [11:0] raddr);
      write_enable = we;
      write_wid    = wwid;
      write_addr   = waddr;
      write_tmask  = wmask;
      write_data   = wdata;
      read_enable  = re;
      read_wid     = rwid;
      read_addr    = raddr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_write();
      write_enable = 1'b0;
      write_tmask  = '0;
   endtask

   task automatic wait_for_valid(input int max_cycles);
      int n;
      n = 0;
      while (!cfg_valid && n < max_cycles) begin
         step();
         n++;
      end
      if (!cfg_valid) checkOutput("wait_cfg_valid_timeout", 256'(cfg_valid), 256'(1));
   endtask

   task automatic read_now(input string name, input logic [1:0] rwid, input logic [11:0] raddr, input logic [31:0] expv);
      read_enable = 1'b1;
      read_wid    = rwid;
      read_addr   = raddr;
      #1;
      checkOutput(name, 256'(read_data), 256'({NL{expv}}));
   endtask

   initial begin
      reset = 1'b0;
      cfg_ready = 1'b1;
      read_uuid = '0; read_pid = '0; read_tmask = '1;
      write_uuid = '0; write_pid = '0;
      applyStimulus(1'b0, 2'd0, BASE, '0, '0, 1'b0, 2'd0, BASE);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      step();

      $display("[TB] reset state");
      checkOutput("rst_cfg_valid", 256'(cfg_valid), 256'(0));
      checkOutput("rst_cfg_wid", 256'(cfg_wid), 256'(0));
      checkOutput("rst_cfg_data", 256'(cfg_data), 256'(0));
      read_now("rst_commit_rd", 2'd0, BASE + 12'd7, 32'h0);

      $display("[TB] basic write/read");
      applyStimulus(1'b1, 2'd1, BASE + 12'd2, 4'b0001, {96'h0, 32'hDEADBEEF}, 1'b1, 2'd1, BASE + 12'd2);
      #1;
`ifndef ROP_CSR_WRITE_BYPASS_EN
      checkOutput("same_cycle_old", 256'(read_data), 256'(0));
`else
      checkOutput("same_cycle_bypass", 256'(read_data), 256'({NL{32'hDEADBEEF}}));
`endif
      step();
      idle_write();
      read_now("w1_rd_deadbeef", 2'd1, BASE + 12'd2, 32'hDEADBEEF);
      read_now("w0_rd_zero", 2'd0, BASE + 12'd2, 32'h0);

      $display("[TB] lane select, empty mask, out of range");
      applyStimulus(1'b1, 2'd1, BASE + 12'd3, 4'b0100, {32'h99, 32'h55, 32'h11, 32'h22}, 1'b0, 2'd0, BASE);
      step();
      applyStimulus(1'b1, 2'd1, BASE + 12'd3, 4'b0000, {4{32'hAA}}, 1'b0, 2'd0, BASE);
      read_now("lane2_sel", 2'd1, BASE + 12'd3, 32'h55);
      step();
      applyStimulus(1'b1, 2'd1, BASE + 12'd8, 4'b0001, {96'h0, 32'h123}, 1'b0, 2'd0, BASE);
      read_now("tmask0_keep", 2'd1, BASE + 12'd3, 32'h55);
      step();
      applyStimulus(1'b1, 2'd1, BASE - 12'd1, 4'b0001, {96'h0, 32'h456}, 1'b0, 2'd0, BASE);
      step();
      idle_write();
      read_now("oor_hi_rd", 2'd1, BASE + 12'd8, 32'h0);
      read_now("oor_lo_rd", 2'd1, BASE - 12'd1, 32'h0);

      $display("[TB] single commit latency");
      applyStimulus(1'b1, 2'd2, BASE + 12'd0, 4'b0001, {96'h0, 32'h20}, 1'b0, 2'd0, BASE);
      step();
      applyStimulus(1'b1, 2'd2, BASE + 12'd6, 4'b0001, {96'h0, 32'h26}, 1'b0, 2'd0, BASE);
      step();
      applyStimulus(1'b1, 2'd2, BASE + 12'd7, 4'b0001, {96'h0, 32'hFFFF}, 1'b0, 2'd0, BASE);
      checkOutput("commit_T_valid", 256'(cfg_valid), 256'(0));
      step();
      idle_write();
      checkOutput("commit_T1_valid", 256'(cfg_valid), 256'(0));
      read_now("commit_pending", 2'd2, BASE + 12'd7, 32'h1);
      step();
      checkOutput("commit_T2_valid", 256'(cfg_valid), 256'(1));
      checkOutput("commit_T2_wid", 256'(cfg_wid), 256'(2));
      checkOutput("commit_T2_r0", 256'(cfg_data[31:0]), 256'(32'h20));
      checkOutput("commit_T2_r6", 256'(cfg_data[6*32 +: 32]), 256'(32'h26));
      read_now("commit_staged", 2'd2, BASE + 12'd7, 32'h2);
      step();
      checkOutput("commit_drain", 256'(cfg_valid), 256'(0));

      $display("[TB] stall then round robin");
      cfg_ready = 1'b0;
      applyStimulus(1'b1, 2'd0, BASE + 12'd7, 4'b0001, '0, 1'b0, 2'd0, BASE);
      step();
      applyStimulus(1'b1, 2'd1, BASE + 12'd7, 4'b0001, '0, 1'b0, 2'd0, BASE);
      step();
      applyStimulus(1'b1, 2'd3, BASE + 12'd7, 4'b0001, '0, 1'b0, 2'd0, BASE);
      step();
      idle_write();
      for (int i = 0; i < 5; i++) begin
         checkOutput("stall_wid0", 256'({cfg_valid, cfg_wid}), 256'({1'b1, 2'd0}));
         step();
      end
      cfg_ready = 1'b1;
      step();
      checkOutput("rr_second_w1", 256'({cfg_valid, cfg_wid}), 256'({1'b1, 2'd1}));
      step();
      checkOutput("rr_third_w3", 256'({cfg_valid, cfg_wid}), 256'({1'b1, 2'd3}));
      step();
      checkOutput("rr_drain", 256'(cfg_valid), 256'(0));

      $display("[TB] frozen snapshot");
      cfg_ready = 1'b0;
      applyStimulus(1'b1, 2'd0, BASE + 12'd7, 4'b0001, '0, 1'b0, 2'd0, BASE);
      step();
      idle_write();
      wait_for_valid(4);
      applyStimulus(1'b1, 2'd0, BASE + 12'd0, 4'b0001, {96'h0, 32'h7}, 1'b0, 2'd0, BASE);
      step();
      applyStimulus(1'b1, 2'd0, BASE + 12'd7, 4'b0001, '0, 1'b0, 2'd0, BASE);
      checkOutput("frozen_r0", 256'(cfg_data[31:0]), 256'(32'h0));
      step();
      idle_write();
      cfg_ready = 1'b1;
      step();
      checkOutput("republish_w0", 256'({cfg_valid, cfg_wid}), 256'({1'b1, 2'd0}));
      checkOutput("republish_r0", 256'(cfg_data[31:0]), 256'(32'h7));
      step();

      $display("[TB] commit in grant cycle");
      applyStimulus(1'b1, 2'd1, BASE + 12'd7, 4'b0001, '0, 1'b0, 2'd0, BASE);
      step();
      applyStimulus(1'b1, 2'd1, BASE + 12'd7, 4'b0001, '0, 1'b0, 2'd0, BASE);
      step();
      idle_write();
      checkOutput("setwin_first", 256'({cfg_valid, cfg_wid}), 256'({1'b1, 2'd1}));
      read_now("setwin_status", 2'd1, BASE + 12'd7, 32'h3);
      step();
      checkOutput("setwin_again", 256'({cfg_valid, cfg_wid}), 256'({1'b1, 2'd1}));
      step();
      checkOutput("setwin_drain", 256'(cfg_valid), 256'(0));

      $display("[TB] reset while holding");
      cfg_ready = 1'b0;
      applyStimulus(1'b1, 2'd3, BASE + 12'd7, 4'b0001, '0, 1'b0, 2'd0, BASE);
      step();
      applyStimulus(1'b1, 2'd2, BASE + 12'd7, 4'b0001, '0, 1'b0, 2'd0, BASE);
      step();
      idle_write();
      wait_for_valid(4);
      reset = 1'b0;
      #1;
      checkOutput("reset_drops_valid", 256'(cfg_valid), 256'(0));
      checkOutput("reset_clears_data", 256'(cfg_data), 256'(0));
      step();
      step();
      reset = 1'b1;
      for (int w = 0; w < NW; w++) begin
         for (int a = 0; a < NC; a++) begin
            read_now("post_reset_rd", 2'(w), BASE + 12'(a), 32'h0);
         end
      end
      step();
      step();
      checkOutput("post_reset_no_publish", 256'(cfg_valid), 256'(0));
      read_enable = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
      $finish;
   end

endmodule
